// File: rtl/otter_pkg.sv
// Shared constants and types for the OTTER ID/EX stage: opcodes, one-hot ALU
// bit positions, operand-source and forwarding-select encodings.
package otter_pkg;

    localparam int ALU_FUN_W = 11;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SLL  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SRL  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_AND  = 7;
    localparam int ALU_SUB  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_PASS = 10;

    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_IMM} op1_src_t;
    typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_src_t;
    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_MEM_WB = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_t;

    function automatic logic [ALU_FUN_W-1:0] alu_onehot(input int idx);
        alu_onehot = ALU_FUN_W'(1) << idx;
    endfunction

endpackage

// File: rtl/otter_alu_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into the one-hot ALU
// function plus the operand-source selects for op1 and op2.
module otter_alu_decode
    import otter_pkg::*;
(
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7b5_i,
    output logic [ALU_FUN_W-1:0] alu_fun_o,
    output op1_src_t             op1_src_o,
    output op2_src_t             op2_src_o
);

    // Bit 30 only distinguishes SUB for register-register ops; ADDI ignores it.
    function automatic logic [ALU_FUN_W-1:0] arith_fun(input logic [2:0] f3,
                                                       input logic b5,
                                                       input logic is_reg);
        case (f3)
            3'b000:  arith_fun = (is_reg && b5) ? alu_onehot(ALU_SUB) : alu_onehot(ALU_ADD);
            3'b001:  arith_fun = alu_onehot(ALU_SLL);
            3'b010:  arith_fun = alu_onehot(ALU_SLT);
            3'b011:  arith_fun = alu_onehot(ALU_SLTU);
            3'b100:  arith_fun = alu_onehot(ALU_XOR);
            3'b101:  arith_fun = b5 ? alu_onehot(ALU_SRA) : alu_onehot(ALU_SRL);
            3'b110:  arith_fun = alu_onehot(ALU_OR);
            default: arith_fun = alu_onehot(ALU_AND);
        endcase
    endfunction

    always_comb begin
        alu_fun_o = '0;
        op1_src_o = OP1_RS1;
        op2_src_o = OP2_RS2;
        case (opcode_i)
            OPC_OP_IMM: begin
                alu_fun_o = arith_fun(funct3_i, funct7b5_i, 1'b0);
                op2_src_o = OP2_IMM;
            end
            OPC_OP: alu_fun_o = arith_fun(funct3_i, funct7b5_i, 1'b1);
            OPC_LUI: begin
                alu_fun_o = alu_onehot(ALU_PASS);
                op1_src_o = OP1_IMM;
            end
            OPC_AUIPC: begin
                alu_fun_o = alu_onehot(ALU_ADD);
                op1_src_o = OP1_PC;
                op2_src_o = OP2_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                alu_fun_o = alu_onehot(ALU_ADD);
                op1_src_o = OP1_PC;
                op2_src_o = OP2_FOUR;
            end
            OPC_LOAD, OPC_STORE: begin
                alu_fun_o = alu_onehot(ALU_ADD);
                op2_src_o = OP2_IMM;
            end
            default: alu_fun_o = '0;
        endcase
    end

endmodule

// File: rtl/otter_id_ex_stage.sv
// ID/EX pipeline register with ALU decode in ID and operand selection plus
// EX/MEM and MEM/WB forwarding in EX.
module otter_id_ex_stage
    import otter_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALU_FUN_W = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic                 funct7b5_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [1:0]           fwd_a_i,
    input  logic [1:0]           fwd_b_i,
    input  logic [XLEN-1:0]      ex_mem_result_i,
    input  logic [XLEN-1:0]      mem_wb_result_i,
    output logic                 valid_o,
    output logic [ALU_FUN_W-1:0] alu_fun_o,
    output logic [XLEN-1:0]      op1_o,
    output logic [XLEN-1:0]      op2_o,
    output logic [XLEN-1:0]      rs2_fwd_o,
    output logic [XLEN-1:0]      pc_o
);

    logic [ALU_FUN_W-1:0] w_alu_fun;
    op1_src_t             w_op1_src;
    op2_src_t             w_op2_src;
    logic [XLEN-1:0]      w_rs1_fwd;
    logic [XLEN-1:0]      w_rs2_fwd;

    logic                 r_valid;
    logic [ALU_FUN_W-1:0] r_alu_fun;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_rs1;
    logic [XLEN-1:0]      r_rs2;
    logic [XLEN-1:0]      r_imm;
    op1_src_t             r_op1_src;
    op2_src_t             r_op2_src;

    otter_alu_decode u_decode (
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .alu_fun_o  (w_alu_fun),
        .op1_src_o  (w_op1_src),
        .op2_src_o  (w_op2_src)
    );

    // valid_o marks a real instruction in EX; a flush bubble is fully cleared
    // so alu_fun stays zero and no stale operands leak into the ALU.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_valid   <= 1'b0;
            r_alu_fun <= '0;
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_op1_src <= OP1_RS1;
            r_op2_src <= OP2_RS2;
        end else if (!stall_i) begin
            r_valid   <= valid_i;
            r_alu_fun <= valid_i ? w_alu_fun : '0;
            r_pc      <= pc_i;
            r_rs1     <= rs1_data_i;
            r_rs2     <= rs2_data_i;
            r_imm     <= imm_i;
            r_op1_src <= w_op1_src;
            r_op2_src <= w_op2_src;
        end
    end

    always_comb begin
        case (fwd_sel_t'(fwd_a_i))
            FWD_EX_MEM: w_rs1_fwd = ex_mem_result_i;
            FWD_MEM_WB: w_rs1_fwd = mem_wb_result_i;
            default:    w_rs1_fwd = r_rs1;
        endcase
        case (fwd_sel_t'(fwd_b_i))
            FWD_EX_MEM: w_rs2_fwd = ex_mem_result_i;
            FWD_MEM_WB: w_rs2_fwd = mem_wb_result_i;
            default:    w_rs2_fwd = r_rs2;
        endcase
    end

    // Only rs-sourced operands see forwarding; pc, imm and the link constant never do.
    always_comb begin
        case (r_op1_src)
            OP1_PC:  op1_o = r_pc;
            OP1_IMM: op1_o = r_imm;
            default: op1_o = w_rs1_fwd;
        endcase
        case (r_op2_src)
            OP2_IMM:  op2_o = r_imm;
            OP2_FOUR: op2_o = XLEN'(4);
            default:  op2_o = w_rs2_fwd;
        endcase
    end

    assign valid_o   = r_valid;
    assign alu_fun_o = r_alu_fun;
    assign pc_o      = r_pc;
    assign rs2_fwd_o = w_rs2_fwd;

endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Bench for otter_id_ex_stage: directed steps from the test plan followed by
// randomized instructions, all compared against an instruction-level model.
module tb_otter_id_ex_stage;

    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_FENCE  = 7'b0001111;
    localparam logic [6:0] T_SYSTEM = 7'b1110011;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        funct7b5_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [31:0] imm_i = '0;
    logic [1:0]  fwd_a_i = '0;
    logic [1:0]  fwd_b_i = '0;
    logic [31:0] ex_mem_result_i = '0;
    logic [31:0] mem_wb_result_i = '0;
    logic        valid_o;
    logic [10:0] alu_fun_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] rs2_fwd_o;
    logic [31:0] pc_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model of what EX currently holds, kept as the raw instruction fields.
    logic        m_valid;
    logic [10:0] m_fun;
    logic [6:0]  m_opc;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic        m_known;

    otter_id_ex_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .opcode_i        (opcode_i),
        .funct3_i        (funct3_i),
        .funct7b5_i      (funct7b5_i),
        .pc_i            (pc_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .imm_i           (imm_i),
        .fwd_a_i         (fwd_a_i),
        .fwd_b_i         (fwd_b_i),
        .ex_mem_result_i (ex_mem_result_i),
        .mem_wb_result_i (mem_wb_result_i),
        .valid_o         (valid_o),
        .alu_fun_o       (alu_fun_o),
        .op1_o           (op1_o),
        .op2_o           (op2_o),
        .rs2_fwd_o       (rs2_fwd_o),
        .pc_o            (pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Bit map: ADD0 SLL1 SLT2 SLTU3 XOR4 SRL5 OR6 AND7 SUB8 SRA9 PASS10.
    // The funct3 encoding of the arithmetic ops happens to equal their bit index.
    function automatic logic [10:0] ref_fun(input logic [6:0] opc, input logic [2:0] f3,
                                            input logic b5);
        int idx;
        idx = -1;
        if (opc == T_OPIMM || opc == T_OP) begin
            idx = int'(f3);
            if (f3 == 3'd5 && b5) idx = 9;
            if (opc == T_OP && f3 == 3'd0 && b5) idx = 8;
        end else if (opc == T_LUI) begin
            idx = 10;
        end else if (opc == T_AUIPC || opc == T_JAL || opc == T_JALR ||
                     opc == T_LOAD || opc == T_STORE) begin
            idx = 0;
        end
        return (idx < 0) ? 11'd0 : (11'd1 << idx);
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ex_mem_result_i;
        if (sel == 2'd2) return mem_wb_result_i;
        return rf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                          input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic v);
        opcode_i = opc; funct3_i = f3; funct7b5_i = b5; pc_i = pc;
        rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm; valid_i = v;
    endtask

    task automatic set_fwd(input logic [1:0] a, input logic [1:0] b,
                           input logic [31:0] exm, input logic [31:0] mwb);
        fwd_a_i = a; fwd_b_i = b; ex_mem_result_i = exm; mem_wb_result_i = mwb;
        #1;
    endtask

    // Advance the model with the inputs present at the edge, then clock the DUT.
    task automatic tick();
        if (rst_i) begin
            m_valid = 0; m_fun = '0; m_opc = T_OP; m_pc = '0;
            m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_known = 1;
        end else if (flush_i) begin
            m_valid = 0; m_fun = '0; m_known = 0; m_opc = '0;
        end else if (!stall_i) begin
            m_valid = valid_i;
            m_fun = valid_i ? ref_fun(opcode_i, funct3_i, funct7b5_i) : 11'd0;
            m_opc = opcode_i; m_pc = pc_i; m_rs1 = rs1_data_i;
            m_rs2 = rs2_data_i; m_imm = imm_i; m_known = 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] r1f, r2f;
        r1f = ref_fwd(fwd_a_i, m_rs1);
        r2f = ref_fwd(fwd_b_i, m_rs2);
        check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m_valid});
        check({tag, ".fun"}, {21'd0, alu_fun_o}, {21'd0, m_fun});
        if (m_known) begin
            check({tag, ".pc"}, pc_o, m_pc);
            check({tag, ".rs2fwd"}, rs2_fwd_o, r2f);
            case (m_opc)
                T_LUI:                   check({tag, ".op1"}, op1_o, m_imm);
                T_AUIPC, T_JAL, T_JALR:  check({tag, ".op1"}, op1_o, m_pc);
                T_OPIMM, T_OP, T_LOAD, T_STORE: check({tag, ".op1"}, op1_o, r1f);
                default: ;
            endcase
            case (m_opc)
                T_OP:                             check({tag, ".op2"}, op2_o, r2f);
                T_OPIMM, T_AUIPC, T_LOAD, T_STORE: check({tag, ".op2"}, op2_o, m_imm);
                T_JAL, T_JALR:                    check({tag, ".op2"}, op2_o, 32'd4);
                default: ;
            endcase
        end
    endtask

    logic [6:0]  opc_tab [12] = '{T_OPIMM, T_OP, T_LUI, T_AUIPC, T_JAL, T_JALR, T_LOAD,
                                  T_STORE, T_BRANCH, T_FENCE, T_SYSTEM, 7'b1111111};
    logic [6:0]  dir_opc [5] = '{T_OP, T_OP, T_OPIMM, T_OPIMM, T_OPIMM};
    logic [2:0]  dir_f3  [5] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd0};
    logic        dir_b5  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [10:0] dir_fun [5] = '{11'h100, 11'h001, 11'h200, 11'h020, 11'h001};

    initial begin
        logic [31:0] h_op1, h_op2, h_pc;
        logic [10:0] h_fun;

        // Reset with an ADD presented on the ID inputs.
        rst_i = 1;
        set_id(T_OP, 3'd0, 1'b0, 32'h200, 32'h5, 32'h6, 32'h7, 1'b1);
        tick();
        tick();
        rst_i = 0;
        set_fwd(2'd0, 2'd0, 32'h0, 32'h0);
        check("reset.valid_k", {31'd0, valid_o}, 32'd0);
        check("reset.fun_k", {21'd0, alu_fun_o}, 32'd0);
        check("reset.pc_k", pc_o, 32'd0);
        check_all("reset");

        // ADDI x1, x2, -5
        set_id(T_OPIMM, 3'd0, 1'b0, 32'h40, 32'd10, 32'h0, 32'hFFFFFFFB, 1'b1);
        tick();
        check("addi.fun_k", {21'd0, alu_fun_o}, 32'h001);
        check("addi.op1_k", op1_o, 32'd10);
        check("addi.op2_k", op2_o, 32'hFFFFFFFB);
        check_all("addi");

        // SUB, ADD, SRAI, SRLI, ADDI with bit30 set.
        for (int i = 0; i < 5; i++) begin
            set_id(dir_opc[i], dir_f3[i], dir_b5[i], 32'h44 + 32'(4 * i), 32'h30 + 32'(i),
                   32'h50 + 32'(i), 32'h3, 1'b1);
            tick();
            check($sformatf("f7.%0d.fun_k", i), {21'd0, alu_fun_o}, {21'd0, dir_fun[i]});
            check_all($sformatf("f7.%0d", i));
        end

        // Operand sources: LUI then JAL.
        set_id(T_LUI, 3'd0, 1'b0, 32'h80, 32'h1, 32'h2, 32'h12345000, 1'b1);
        tick();
        check("lui.fun_k", {21'd0, alu_fun_o}, 32'h400);
        check("lui.op1_k", op1_o, 32'h12345000);
        set_id(T_JAL, 3'd0, 1'b0, 32'h100, 32'h1, 32'h2, 32'h800, 1'b1);
        tick();
        check("jal.fun_k", {21'd0, alu_fun_o}, 32'h001);
        check("jal.op1_k", op1_o, 32'h100);
        check("jal.op2_k", op2_o, 32'd4);
        check_all("jal");

        // Forwarding on an OP instruction, then select 11 falls back to regfile.
        set_id(T_OP, 3'd7, 1'b0, 32'h104, 32'h11, 32'h22, 32'h0, 1'b1);
        tick();
        set_fwd(2'd1, 2'd2, 32'hAA, 32'hBB);
        check("fwd.op1_k", op1_o, 32'hAA);
        check("fwd.op2_k", op2_o, 32'hBB);
        check("fwd.rs2_k", rs2_fwd_o, 32'hBB);
        check_all("fwd");
        set_fwd(2'd3, 2'd3, 32'hAA, 32'hBB);
        check("fwd11.op1_k", op1_o, 32'h11);
        check("fwd11.op2_k", op2_o, 32'h22);
        check_all("fwd11");
        set_fwd(2'd0, 2'd0, 32'h0, 32'h0);

        // Stall for three cycles while the ID inputs change.
        set_id(T_OPIMM, 3'd6, 1'b0, 32'h108, 32'h0F0, 32'h0, 32'h00F, 1'b1);
        tick();
        h_fun = alu_fun_o; h_op1 = op1_o; h_op2 = op2_o; h_pc = pc_o;
        check("ori.fun_k", {21'd0, h_fun}, 32'h040);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(T_LUI, 3'(i), 1'b1, 32'h900 + 32'(i), 32'(i), 32'(i), 32'hABC00000, 1'b1);
            tick();
            check($sformatf("stall.%0d.fun_k", i), {21'd0, alu_fun_o}, {21'd0, h_fun});
            check($sformatf("stall.%0d.op1_k", i), op1_o, h_op1);
            check($sformatf("stall.%0d.op2_k", i), op2_o, h_op2);
            check($sformatf("stall.%0d.pc_k", i), pc_o, h_pc);
            check_all($sformatf("stall.%0d", i));
        end
        flush_i = 1;
        tick();
        check("flush.valid_k", {31'd0, valid_o}, 32'd0);
        check("flush.fun_k", {21'd0, alu_fun_o}, 32'd0);
        check_all("flush");
        stall_i = 0;
        flush_i = 0;

        set_id(T_BRANCH, 3'd1, 1'b0, 32'h200, 32'h3, 32'h4, 32'h10, 1'b1);
        tick();
        check("branch.fun_k", {21'd0, alu_fun_o}, 32'd0);
        check("branch.valid_k", {31'd0, valid_o}, 32'd1);
        check_all("branch");

        // Randomized instruction stream with occasional stalls, flushes and bubbles.
        for (int i = 0; i < 80; i++) begin
            set_id(opc_tab[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 5) != 0);
            stall_i = ($urandom_range(0, 5) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            tick();
            stall_i = 0;
            flush_i = 0;
            set_fwd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            check_all($sformatf("rnd.%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/otter_id_ex_stage.md
Name: otter_id_ex_stage

Overview:
ID/EX pipeline stage for the 5-stage RV32I core, directly upstream of the one-hot ALU. Decodes opcode/funct fields into the 11-bit one-hot ALU function in the ID cycle and registers it with operands, PC and immediate. In the EX cycle it applies operand-source selection and EX/MEM and MEM/WB forwarding to drive the ALU's op1/op2. Stall and flush inputs come from the hazard unit.

Parameters:
XLEN, 32, datapath width
ALU_FUN_W, 11, one-hot ALU function width

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
stall_i  in  1  hold the ID/EX register contents
flush_i  in  1  replace the next ID/EX contents with a bubble
valid_i  in  1  ID holds a real instruction
opcode_i  in  7  instr[6:0]
funct3_i  in  3  instr[14:12]
funct7b5_i  in  1  instr[30]
pc_i  in  32  PC of the ID instruction
rs1_data_i  in  32  register file read port 1
rs2_data_i  in  32  register file read port 2
imm_i  in  32  sign-extended immediate for this format
fwd_a_i  in  2  EX-cycle forward select for rs1: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 regfile
fwd_b_i  in  2  EX-cycle forward select for rs2, same encoding
ex_mem_result_i  in  32  EX/MEM forwarding value
mem_wb_result_i  in  32  MEM/WB forwarding value
valid_o  out  1  EX holds a real instruction
alu_fun_o  out  11  one-hot ALU function, or all zero
op1_o  out  32  ALU operand 1
op2_o  out  32  ALU operand 2
rs2_fwd_o  out  32  forwarded rs2, used for store data and branch compare
pc_o  out  32  registered PC

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high. On reset all registers clear: valid_o=0, alu_fun_o=0, pc_o=0. Stored rs1, rs2, imm and source selects clear to 0. op1_o, op2_o and rs2_fwd_o are then 0 unless forwarding selects a non-zero bus.
- Latency: 1 cycle from the ID inputs to the registered outputs. op1_o, op2_o and rs2_fwd_o are combinational from the registered values and the EX-cycle forwarding inputs.
- ALU function bit map: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA, 10 PASS_OP1.
- Decode (ID cycle, combinational):
  - OP-IMM (0010011): funct3 map 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (funct7b5=1 selects SRA), 110 OR, 111 AND. Bit 30 is ignored for ADDI. Sources: op1=rs1, op2=imm.
  - OP (0110011): same funct3 map, plus funct3=000 with funct7b5=1 gives SUB. Sources: op1=rs1, op2=rs2.
  - LUI: PASS_OP1 with op1=imm.
  - AUIPC: ADD with op1=pc, op2=imm.
  - JAL and JALR: ADD with op1=pc, op2=constant 4 (link address).
  - LOAD and STORE: ADD with op1=rs1, op2=imm.
  - BRANCH, FENCE, SYSTEM and any unknown opcode: alu_fun=0.
- Register update priority (highest first):
  1. rst_i
  2. flush_i: load a bubble (valid=0, alu_fun=0); wins over stall_i.
  3. stall_i: hold every register.
  4. otherwise load the decoded values. If valid_i=0, load alu_fun=0 and valid=0.
- Invariant: alu_fun_o is always one-hot or zero, in every cycle including after reset, flush and stall.
- Forwarding (EX cycle):
  - rs1_fwd = mux(fwd_a_i); rs2_fwd = mux(fwd_b_i). Select 11 behaves as 00.
  - op1_o = rs1_fwd, pc or imm according to the registered op1 source.
  - op2_o = rs2_fwd, imm or 32'd4 according to the registered op2 source.
  - Forwarding affects only rs-sourced operands; pc, imm and the constant are never forwarded.
- While stalled, op outputs still follow live forwarding inputs, so the hazard unit must keep the selects valid.

Decomposition:
- Package otter_pkg:
  - opcode localparams
  - ALU bit index constants (ALU_ADD=0 ... ALU_PASS=10)
  - op1_src_t enum {OP1_RS1, OP1_PC, OP1_IMM}
  - op2_src_t enum {OP2_RS2, OP2_IMM, OP2_FOUR}
  - fwd_sel_t enum
- Sub-module otter_alu_decode: purely combinational. Maps opcode/funct3/funct7b5 to {alu_fun, op1_src, op2_src}.

Test Plan:
- Reset: rst_i=1 for 2 cycles with valid_i=1, ADD decode on the inputs -> valid_o=0, alu_fun_o=0, pc_o=0.
- Decode: ADDI x1, x2, -5 with rs1=10, imm=0xFFFFFFFB, fwd=00 -> next cycle alu_fun_o=11'h001, op1_o=10, op2_o=0xFFFFFFFB.
- Decode: SUB vs ADD vs SRAI/SRLI with funct7b5 toggled -> alu_fun_o=11'h100, 11'h001, 11'h200, 11'h020 respectively; ADDI with bit30=1 still gives 11'h001.
- Operand sources: LUI imm=0x12345000 -> alu_fun_o=11'h400, op1_o=0x12345000. JAL pc=0x100 -> op1_o=0x100, op2_o=4, alu_fun_o=11'h001.
- Forwarding: OP instruction loaded, then in EX fwd_a=01 (EX/MEM=0xAA), fwd_b=10 (MEM/WB=0xBB) -> op1_o=0xAA, op2_o=0xBB, rs2_fwd_o=0xBB. Select 11 -> regfile values.
- Control: stall_i=1 for 3 cycles while the inputs change -> outputs unchanged. stall_i=1 together with flush_i=1 -> valid_o=0, alu_fun_o=0 next cycle. BRANCH opcode -> alu_fun_o=0, valid_o=1.
